uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an input FIFO, the next-generation serial TX for the SoC debug/console path.

---
 rtl/uart_tx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
// Frames are start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits.
// Each bit is held for CLKS_PER_BIT clocks, and back-to-back frames have no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic                               tx,
  output logic                               busy,
  output logic                               byte_end,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = 4;

  localparam bit PARAMS_OK =
    (CLKS_PER_BIT >= 2) && (CLKS_PER_BIT <= 65535) &&
    (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
    (PARITY <= 2) &&
    ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
    (FIFO_DEPTH >= 2) && (FIFO_DEPTH <= 64) &&
    ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!PARAMS_OK) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          used_c;
  logic                   full_c, empty_c, push_c, pop_c;
  logic [DATA_BITS-1:0]   head_c;

  logic                   tx_q, tx_d;
  logic                   byte_end_q, byte_end_d;
  logic [BW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   bit_last_c, data_last_c, stop_last_c;

  // FIFO occupancy: the extra pointer bit separates full from empty
  assign used_c     = wr_ptr_q - rd_ptr_q;
  assign full_c     = (used_c == PW'(FIFO_DEPTH));
  assign empty_c    = (wr_ptr_q == rd_ptr_q);
  assign push_c     = data_valid && !full_c;
  assign head_c     = mem_q[rd_ptr_q[AW-1:0]];
  assign data_ready = !full_c;
  assign fifo_count = CW'(used_c);

  assign bit_last_c  = (cnt_q == BW'(CLKS_PER_BIT - 1));
  assign data_last_c = (idx_q == IW'(DATA_BITS - 1));
  assign stop_last_c = (idx_q == IW'(STOP_BITS - 1));

  assign tx       = tx_q;
  assign byte_end = byte_end_q;
  assign busy     = (state_q != S_IDLE);

  // FIFO pointers; reset discards every queued word
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage, written only when a push is accepted
  always_ff @(posedge clk) begin
    if (reset && push_c) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and pop decision; a pop always coincides with entry to START
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          state_d = S_START;
          pop_c   = 1'b1;
        end
      end
      S_START: begin
        if (bit_last_c) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_last_c && data_last_c) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_last_c) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_last_c && stop_last_c) begin
          if (!empty_c) begin
            state_d = S_START;
            pop_c   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line value, bit/index counters and shift register for the next cycle
  always_comb begin
    tx_d       = tx_q;
    byte_end_d = 1'b0;
    cnt_d      = bit_last_c ? '0 : cnt_q + BW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    if (pop_c) begin
      shift_d = head_c;
      par_d   = (PARITY == 2) ? ^head_c : ~^head_c;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = !pop_c;
      end
      S_START: begin
        if (bit_last_c) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_last_c) begin
          if (data_last_c) begin
            idx_d = '0;
            tx_d  = (PARITY != 0) ? par_q : 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_last_c) begin
          tx_d  = 1'b1;
          idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_last_c) begin
          if (stop_last_c) begin
            byte_end_d = 1'b1;
            idx_d      = '0;
            tx_d       = !pop_c;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // Datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_q       <= 1'b1;
      byte_end_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      byte_end_q <= byte_end_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one stimulus stream.
// Each configuration has a queue-based model that expands every popped word into its expected per-clock line values.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] data_in;
  logic       data_valid;
  bit         checking;
  int         n_checks;
  int         n_errors;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int unsigned CPB = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 2 : 5;
    localparam int unsigned DB  = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 7 : 9;
    localparam int unsigned PAR = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    localparam int unsigned SB  = (g == 2) ? 2 : 1;
    localparam int unsigned D   = (g == 2) ? 2 : (g == 3) ? 8 : 4;
    localparam int unsigned CW  = $clog2(D + 1);

    logic          tx, busy, byte_end, data_ready;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .PARITY       (PAR),
      .STOP_BITS    (SB),
      .FIFO_DEPTH   (D)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in[DB-1:0]),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .tx         (tx),
      .busy       (busy),
      .byte_end   (byte_end),
      .fifo_count (fifo_count)
    );

    int unsigned fq[$];
    bit          lq[$];
    bit          be_exp;

    // Reference: word queue plus the remaining line values of the frame on the wire
    always @(posedge clk) begin : p_model
      bit          acc;
      bit          was_busy;
      bit          pb;
      int unsigned w;
      acc = (data_valid === 1'b1) && (fq.size() < D);
      if (reset !== 1'b1) begin
        fq.delete();
        lq.delete();
        be_exp = 1'b0;
      end else begin
        was_busy = (lq.size() != 0);
        if (was_busy) void'(lq.pop_front());
        be_exp = was_busy && (lq.size() == 0);
        if ((lq.size() == 0) && (fq.size() != 0)) begin
          w  = fq.pop_front();
          pb = (($countones(w) % 2) == 1) == (PAR == 2);
          for (int k = 0; k < CPB; k++) lq.push_back(1'b0);
          for (int b = 0; b < DB; b++)
            for (int k = 0; k < CPB; k++) lq.push_back(w[b]);
          if (PAR != 0)
            for (int k = 0; k < CPB; k++) lq.push_back(pb);
          for (int k = 0; k < SB * CPB; k++) lq.push_back(1'b1);
        end
        if (acc) fq.push_back(int'(data_in) & ((1 << DB) - 1));
      end
    end

    // Compare every visible output mid-cycle
    always @(negedge clk) begin
      if (checking) begin
        check_eq($sformatf("cfg%0d.tx", g), int'(tx), (lq.size() != 0) ? int'(lq[0]) : 1);
        check_eq($sformatf("cfg%0d.busy", g), int'(busy), int'(lq.size() != 0));
        check_eq($sformatf("cfg%0d.byte_end", g), int'(byte_end), int'(be_exp));
        check_eq($sformatf("cfg%0d.fifo_count", g), int'(fifo_count), fq.size());
        check_eq($sformatf("cfg%0d.data_ready", g), int'(data_ready), int'(fq.size() < D));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [8:0] d);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    checking   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // isolated frames with known parity outcomes
    push_one(9'h0A5); idle(80);
    push_one(9'h007); idle(80);
    push_one(9'h07F); idle(80);
    push_one(9'h1FF); idle(80);

    // valid held high: fill to full, refused pushes, refill at frame boundaries
    data_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      data_in = 9'(i + 1);
      @(negedge clk);
    end
    data_valid = 1'b0;
    idle(700);

    // reset pulse mid-frame with words queued, then a fresh word
    data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 9'($urandom);
      @(negedge clk);
    end
    data_valid = 1'b0;
    idle(12);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    push_one(9'h03C); idle(100);

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = 9'($urandom);
      reset      = ((i % 997) == 500) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    reset      = 1'b1;
    idle(700);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
